dip_frame_reader: RTL and testbench

//  Read side of the DIP SDRAM path. Pulls one RGB565 word per pixel from the SDRAM read FIFO
//  and converts it to an 8-bit grey level. Emits a raster-ordered dip_en/dip_data pixel stream.
//  The stream drives the 3x3 window and morphology filters, and frame_done marks the end of frame.

---
 rtl/dip_frame_reader.sv | 123 ++++++++++++
 tb/tb_dip_frame_reader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dip_frame_reader.sv
// dip_frame_reader: pulls RGB565 words from the SDRAM read FIFO, converts each
// to an 8-bit grey level and emits a raster-ordered pixel stream with an
// end-of-frame pulse. Pop -> FIFO word -> registered pixel is a fixed 2-cycle path.
module dip_frame_reader #(
  parameter logic [15:0] CNT_COL_MAX = 16'd1023,
  parameter logic [15:0] CNT_ROW_MAX = 16'd767
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        sdram_rd_empty,
  output logic        sdram_rd_en,
  input  logic [15:0] sdram_rd_data,
  output logic        dip_en,
  output logic [7:0]  dip_data,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] col;
  logic [15:0] row;
  logic        pop;
  logic        last_pop;
  logic        vld_p0;
  logic        last_p0;

  // Channels are left-justified into 8 bits with zero fill, then weighted.
  // The largest possible sum (64088) fits easily in 18 bits, so no clamp.
  function automatic logic [7:0] rgb565_to_grey(input logic [15:0] px);
    logic [17:0] r8;
    logic [17:0] g8;
    logic [17:0] b8;
    logic [17:0] acc;
    r8  = {10'd0, px[15:11], 3'b000};
    g8  = {10'd0, px[10:5], 2'b00};
    b8  = {10'd0, px[4:0], 3'b000};
    acc = 18'd77 * r8 + 18'd150 * g8 + 18'd29 * b8;
    return 8'(acc >> 8);
  endfunction

  // Pop only while a frame is being fetched and the FIFO has data.
  assign sdram_rd_en = (state == RUN) && !sdram_rd_empty;
  assign pop         = sdram_rd_en;
  assign last_pop    = pop && (col == CNT_COL_MAX) && (row == CNT_ROW_MAX);

  // Frame sequencing and raster pop counters; counters hold on FIFO stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      col   <= 16'd0;
      row   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          col <= 16'd0;
          row <= 16'd0;
          if (frame_start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (pop) begin
            if (col == CNT_COL_MAX) begin
              col <= 16'd0;
              row <= (row == CNT_ROW_MAX) ? 16'd0 : row + 16'd1;
            end else begin
              col <= col + 16'd1;
            end
          end
          if (last_pop) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (frame_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Valid and end-of-frame markers travel alongside the FIFO word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0     <= 1'b0;
      last_p0    <= 1'b0;
      dip_en     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // p0: FIFO word is presented on sdram_rd_data this cycle
      vld_p0     <= pop;
      last_p0    <= last_pop;
      // p1: registered grey pixel and strobes
      dip_en     <= vld_p0;
      frame_done <= vld_p0 && last_p0;
    end
  end

  // Grey conversion of the word returned by the FIFO, captured only when valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dip_data <= 8'd0;
    end else if (vld_p0) begin
      dip_data <= rgb565_to_grey(sdram_rd_data);
    end
  end

endmodule

// File: tb/tb_dip_frame_reader.sv
// Bench for dip_frame_reader on an 8-pixel (4x2) frame: a FIFO model feeds the
// DUT, a cycle-level reference tracks what every output must be, and directed
// checks pin conversion values, timing, retrigger and reset behaviour.
module tb_dip_frame_reader;

  localparam int NPX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        empty_gate = 1'b0;
  logic        sdram_rd_empty;
  logic        sdram_rd_en;
  logic [15:0] sdram_rd_data = 16'd0;
  logic        dip_en;
  logic [7:0]  dip_data;
  logic        busy;
  logic        frame_done;

  logic [15:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int pop_cyc_q[$];
  int en_cyc_q[$];
  int done_cyc_q[$];
  int data_q[$];

  typedef struct {
    int due;
    int data;
    bit last;
  } pix_t;
  pix_t pq[$];

  int m_rd = 0;
  int m_pops = 0;
  bit m_run = 1'b0;
  bit m_busy = 1'b0;

  dip_frame_reader #(
    .CNT_COL_MAX(16'd3),
    .CNT_ROW_MAX(16'd1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .sdram_rd_empty(sdram_rd_empty),
    .sdram_rd_en(sdram_rd_en),
    .sdram_rd_data(sdram_rd_data),
    .dip_en(dip_en),
    .dip_data(dip_data),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign sdram_rd_empty = empty_gate || (wr_ptr == rd_ptr);

  // FIFO model: a pop returns its word on the following cycle
  always @(posedge clk) begin
    if (sdram_rd_en && !sdram_rd_empty) begin
      sdram_rd_data <= mem[rd_ptr[5:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  function automatic int grey_of(input logic [15:0] w);
    int r;
    int g;
    int b;
    r = int'(w[15:11]) * 8;
    g = int'(w[10:5]) * 4;
    b = int'(w[4:0]) * 8;
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr++;
  endtask

  task automatic start_frame(output int t0);
    frame_start = 1'b1;
    t0 = cyc;
    tick();
    frame_start = 1'b0;
  endtask

  // Reference: a frame is 8 pops taken whenever the FIFO is non-empty; each
  // popped word reappears as a grey pixel exactly 2 cycles later; the 8th
  // pixel carries frame_done and busy drops on the cycle after it.
  task automatic monitor();
    bit   exp_rd;
    bit   exp_en;
    bit   exp_done;
    bit   cur_busy;
    pix_t p;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_run  = 1'b0;
        m_busy = 1'b0;
        m_pops = 0;
        pq.delete();
      end else begin
        exp_rd   = m_run && !sdram_rd_empty;
        exp_en   = (pq.size() > 0) && (pq[0].due == cyc);
        exp_done = exp_en && pq[0].last;
        chk("rd_en", int'(sdram_rd_en), int'(exp_rd));
        chk("dip_en", int'(dip_en), int'(exp_en));
        chk("frame_done", int'(frame_done), int'(exp_done));
        chk("busy", int'(busy), int'(m_busy));
        if (exp_en) chk("dip_data", int'(dip_data), pq[0].data);
        if (sdram_rd_en) pop_cyc_q.push_back(cyc);
        if (dip_en) begin
          en_cyc_q.push_back(cyc);
          data_q.push_back(int'(dip_data));
        end
        if (frame_done) done_cyc_q.push_back(cyc);
        cur_busy = m_busy;
        if (exp_en) pq.delete(0);
        if (exp_done) m_busy = 1'b0;
        if (exp_rd) begin
          p.due  = cyc + 2;
          p.data = grey_of(mem[m_rd[5:0]]);
          p.last = (m_pops == NPX - 1);
          pq.push_back(p);
          m_rd++;
          m_pops++;
          if (m_pops == NPX) m_run = 1'b0;
        end
        if (!cur_busy && frame_start) begin
          m_busy = 1'b1;
          m_run  = 1'b1;
          m_pops = 0;
        end
      end
      cyc++;
    end
  endtask

  initial begin
    int t0;
    int bp;
    int be;
    int bd;
    int bptr;
    fork
      monitor();
    join_none

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", int'(sdram_rd_en), 0);
    chk("rst_dip_en", int'(dip_en), 0);
    chk("rst_dip_data", int'(dip_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    rst = 1'b0;
    tick();
    tick();

    // full FIFO: conversion values and fixed timing
    push(16'h0000); push(16'hFFFF); push(16'hF800); push(16'h07E0);
    push(16'h001F); push(16'h1234); push(16'hABCD); push(16'h8410);
    bp = pop_cyc_q.size(); be = en_cyc_q.size(); bd = done_cyc_q.size();
    start_frame(t0);
    repeat (14) tick();
    chk("full_pops", pop_cyc_q.size() - bp, 8);
    chk("full_first_pop", (pop_cyc_q.size() > bp) ? pop_cyc_q[bp] - t0 : -1, 1);
    chk("full_last_pop", (pop_cyc_q.size() > bp + 7) ? pop_cyc_q[bp + 7] - t0 : -1, 8);
    chk("full_en_count", en_cyc_q.size() - be, 8);
    chk("full_first_en", (en_cyc_q.size() > be) ? en_cyc_q[be] - t0 : -1, 3);
    chk("full_last_en", (en_cyc_q.size() > be + 7) ? en_cyc_q[be + 7] - t0 : -1, 10);
    chk("full_done_count", done_cyc_q.size() - bd, 1);
    chk("full_done_cyc", (done_cyc_q.size() > bd) ? done_cyc_q[bd] - t0 : -1, 10);
    chk("grey_0000", (data_q.size() > be) ? data_q[be] : -1, 0);
    chk("grey_FFFF", (data_q.size() > be + 1) ? data_q[be + 1] : -1, 250);
    chk("grey_F800", (data_q.size() > be + 2) ? data_q[be + 2] : -1, 74);
    chk("grey_07E0", (data_q.size() > be + 3) ? data_q[be + 3] : -1, 147);
    chk("grey_001F", (data_q.size() > be + 4) ? data_q[be + 4] : -1, 28);
    chk("full_busy_after", int'(busy), 0);

    // FIFO empty toggling every other cycle
    push(16'h001F); push(16'h07E0); push(16'hF800); push(16'h0000);
    push(16'h1234); push(16'h8410); push(16'hABCD); push(16'hFFFF);
    bp = pop_cyc_q.size(); be = en_cyc_q.size(); bd = done_cyc_q.size();
    empty_gate = 1'b1;
    start_frame(t0);
    for (int i = 0; i < 30; i++) begin
      empty_gate = ~empty_gate;
      tick();
    end
    empty_gate = 1'b0;
    tick();
    chk("tog_pops", pop_cyc_q.size() - bp, 8);
    chk("tog_en_count", en_cyc_q.size() - be, 8);
    chk("tog_done_count", done_cyc_q.size() - bd, 1);
    chk("tog_done_on_8th",
        (done_cyc_q.size() > bd && en_cyc_q.size() > be + 7) ? done_cyc_q[bd] - en_cyc_q[be + 7] : -1, 0);
    chk("tog_first_px", (data_q.size() > be) ? data_q[be] : -1, 28);
    chk("tog_last_px", (data_q.size() > be + 7) ? data_q[be + 7] : -1, 250);

    // frame_start retriggered mid-frame and on the frame_done cycle
    for (int i = 0; i < 8; i++) push(16'(16'h1111 * (i + 1)));
    bp = pop_cyc_q.size(); be = en_cyc_q.size(); bd = done_cyc_q.size();
    start_frame(t0);
    repeat (3) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (5) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (4) tick();
    chk("retrig_pops", pop_cyc_q.size() - bp, 8);
    chk("retrig_en_count", en_cyc_q.size() - be, 8);
    chk("retrig_done_count", done_cyc_q.size() - bd, 1);
    chk("retrig_done_cyc", (done_cyc_q.size() > bd) ? done_cyc_q[bd] - t0 : -1, 10);
    chk("retrig_idle_busy", int'(busy), 0);
    chk("retrig_no_extra_pop", pop_cyc_q.size() - bp, 8);
    for (int i = 0; i < 8; i++) push(16'(16'h0841 * (i + 3)));
    bp = pop_cyc_q.size(); be = en_cyc_q.size(); bd = done_cyc_q.size();
    start_frame(t0);
    repeat (14) tick();
    chk("restart_pops", pop_cyc_q.size() - bp, 8);
    chk("restart_en_count", en_cyc_q.size() - be, 8);
    chk("restart_done_count", done_cyc_q.size() - bd, 1);

    // reset after 5 pops
    for (int i = 0; i < 8; i++) push(16'(16'h2108 * (i + 1)));
    bptr = rd_ptr;
    bd = done_cyc_q.size();
    start_frame(t0);
    for (int i = 0; i < 20 && (rd_ptr - bptr) < 5; i++) tick();
    chk("rst_reach_5_pops", rd_ptr - bptr, 5);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rd_en", int'(sdram_rd_en), 0);
    chk("async_dip_en", int'(dip_en), 0);
    chk("async_dip_data", int'(dip_data), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_frame_done", int'(frame_done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_no_done", done_cyc_q.size() - bd, 0);
    for (int i = 0; i < 5; i++) push(16'(16'h4210 + 16'(i)));
    bp = pop_cyc_q.size(); be = en_cyc_q.size(); bd = done_cyc_q.size();
    start_frame(t0);
    repeat (14) tick();
    chk("post_rst_pops", pop_cyc_q.size() - bp, 8);
    chk("post_rst_en_count", en_cyc_q.size() - be, 8);
    chk("post_rst_done_count", done_cyc_q.size() - bd, 1);
    chk("post_rst_done_cyc", (done_cyc_q.size() > bd) ? done_cyc_q[bd] - t0 : -1, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
